sobel_window_engine: RTL

- Consumer end of the compute-buffer handshake. Waits for a computeSobel strobe, then samples the 3x8 grayscale window buffer and the column pointer.
- Computes the 3x3 Sobel gradient magnitude centred on that column and returns one edge pixel plus an edge flag.
- Raises getMatrix when ready for the next window.
- Sits between the window buffer builder and the edge-pixel writer.

---
 rtl/sobel_window_engine.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sobel_window_engine.sv
// Sobel edge engine: captures a 3-row window on computeSobel and returns one saturated gradient pixel.
// Optional SOBEL_EDGE_COUNT_EN adds a saturating count of detected edges on edge_count.
module sobel_window_engine #(
    parameter int PIX_W   = 8,
    parameter int ROW_LEN = 8,
    parameter int THRESH  = 100
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     computeSobel,
    input  logic [2:0][ROW_LEN-1:0][PIX_W-1:0]       window_buffer,
    input  logic [$clog2(ROW_LEN)-1:0]               column,
    output logic                                     getMatrix,
    output logic                                     edge_valid,
    output logic [PIX_W-1:0]                         edge_pixel,
    output logic                                     edge_detected,
`ifdef SOBEL_EDGE_COUNT_EN
    output logic [15:0]                              edge_count,
`endif
    output logic                                     busy
);

    localparam int COL_W = $clog2(ROW_LEN);
    localparam int SUM_W = PIX_W + 2;   // a + 2b + c
    localparam int GRD_W = PIX_W + 3;   // signed difference, also holds |Gx|+|Gy|
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROW_LEN - 1);
    localparam logic [GRD_W-1:0] SAT_MAX = GRD_W'({PIX_W{1'b1}});

    typedef enum logic [1:0] {IDLE, GRAD, MAG, DONE} state_t;

    state_t state, state_nxt;

    logic [2:0][ROW_LEN-1:0][PIX_W-1:0] win_q;
    logic [COL_W-1:0]                   col_q;
    logic [COL_W-1:0]                   col_in;
    logic [COL_W-1:0]                   l_idx, r_idx;
    logic signed [GRD_W-1:0]            gx_d, gy_d, gx_q, gy_q;
    logic [GRD_W-1:0]                   abs_x, abs_y, mag;
    logic                               start;

    function automatic logic [SUM_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    assign start  = (state == IDLE) && computeSobel;
    assign col_in = (int'(column) >= ROW_LEN) ? COL_MAX : column;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (computeSobel) state_nxt = GRAD;
            GRAD:    state_nxt = MAG;
            MAG:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        getMatrix = (state == IDLE);
        busy      = !getMatrix;
    end

    // NOTE: the captured window is plain storage qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            win_q <= window_buffer;
            col_q <= col_in;
        end
    end

    // Edge columns replicate their own pixel instead of wrapping.
    always_comb begin
        l_idx = (col_q == '0)      ? col_q : col_q - 1'b1;
        r_idx = (col_q == COL_MAX) ? col_q : col_q + 1'b1;
        gx_d  = $signed({1'b0, wsum(win_q[2][r_idx], win_q[1][r_idx], win_q[0][r_idx])})
              - $signed({1'b0, wsum(win_q[2][l_idx], win_q[1][l_idx], win_q[0][l_idx])});
        gy_d  = $signed({1'b0, wsum(win_q[0][l_idx], win_q[0][col_q], win_q[0][r_idx])})
              - $signed({1'b0, wsum(win_q[2][l_idx], win_q[2][col_q], win_q[2][r_idx])});
    end

    always_comb begin
        abs_x = gx_q[GRD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_y = gy_q[GRD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag   = abs_x + abs_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q          <= '0;
            gy_q          <= '0;
            edge_valid    <= 1'b0;
            edge_pixel    <= '0;
            edge_detected <= 1'b0;
        end else begin
            edge_valid <= (state == MAG);
            if (state == GRAD) begin
                gx_q <= gx_d;
                gy_q <= gy_d;
            end
            if (state == MAG) begin
                edge_pixel    <= (mag > SAT_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
                edge_detected <= (int'(mag) >= THRESH);
            end
        end
    end

`ifdef SOBEL_EDGE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            edge_count <= '0;
        else if (edge_valid && edge_detected && (edge_count != 16'hFFFF))
            edge_count <= edge_count + 16'd1;
    end
`endif

endmodule
